// File: rtl/cp0_pkg.sv
// CP0 register numbers, exception codes and Status/Cause field positions
// shared by the coprocessor-0 block and its timer.
package cp0_pkg;

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_STATUS  = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;
  localparam logic [4:0] CP0_PRID    = 5'd15;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_RI  = 5'd10;
  localparam logic [4:0] EXC_OV  = 5'd12;

  localparam int ST_IE    = 0;
  localparam int ST_EXL   = 1;
  localparam int ST_IM_LO = 10;
  localparam int ST_IM_HI = 15;

  localparam int CA_EXC_LO = 2;
  localparam int CA_EXC_HI = 6;
  localparam int CA_IP_LO  = 10;
  localparam int CA_IP_HI  = 15;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer; raises pending on a Count==Compare match
// and holds it until Compare is rewritten.
module cp0_timer #(
  parameter bit TIMER_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        pending_o
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        pending_q, pending_d;

  always_comb begin
    count_d   = count_q;
    compare_d = compare_q;
    pending_d = pending_q;
    if (compare_we) compare_d = wdata;
    if (TIMER_EN) begin
      count_d = count_we ? wdata : count_q + 32'd1;
      // match uses pre-edge values; a Compare write wins
      if (compare_we)
        pending_d = 1'b0;
      else if (count_q == compare_q)
        pending_d = 1'b1;
    end else begin
      count_d   = '0;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= '0;
      compare_q <= 32'hFFFF_FFFF;
      pending_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      pending_q <= pending_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign pending_o = pending_q;

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor 0: exception/interrupt arbitration, EPC for the PC mux,
// MTC0/MFC0 access, ERET and the Count/Compare timer interrupt.
module cp0_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID     = 32'h0001_8000,
  parameter bit          TIMER_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        isCOP0,
  input  logic        isMtc0,
  input  logic        isMfc0,
  input  logic        isEret,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] wdata,
  input  logic        ri_exc,
  input  logic        sys_exc,
  input  logic        ov_exc,
  input  logic [4:0]  ext_int,
  output logic [31:0] rdata,
  output logic        hasExp,
  output logic [31:0] cp0_target_addr,
  output logic [31:0] status_o,
  output logic [31:0] cause_o
);

  logic        ie_q, ie_d;
  logic        exl_q, exl_d;
  logic [5:0]  im_q, im_d;
  logic [4:0]  exc_q, exc_d;
  logic [31:0] epc_q, epc_d;

  logic [31:0] count, compare;
  logic        pending;
  logic [5:0]  ip;
  logic        int_req, sync_req;
  logic        mtc0_en, eret_en;
  logic [4:0]  win_code;
  logic        unused_mfc0;

  assign unused_mfc0 = isMfc0;

  assign ip       = {pending, ext_int};
  assign int_req  = ie_q & ~exl_q & |(ip & im_q);
  assign sync_req = ri_exc | sys_exc | ov_exc;
  assign hasExp   = ~rst & (int_req | sync_req);
  assign mtc0_en  = isCOP0 & isMtc0 & ~hasExp;
  assign eret_en  = isCOP0 & isEret & ~hasExp;

  always_comb begin
    if (int_req)      win_code = EXC_INT;
    else if (ri_exc)  win_code = EXC_RI;
    else if (sys_exc) win_code = EXC_SYS;
    else              win_code = EXC_OV;
  end

  cp0_timer #(.TIMER_EN(TIMER_EN)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (mtc0_en && cp0_addr == CP0_COUNT),
    .compare_we (mtc0_en && cp0_addr == CP0_COMPARE),
    .wdata      (wdata),
    .count_o    (count),
    .compare_o  (compare),
    .pending_o  (pending)
  );

  always_comb begin
    ie_d  = ie_q;
    exl_d = exl_q;
    im_d  = im_q;
    exc_d = exc_q;
    epc_d = epc_q;
    if (hasExp) begin
      exc_d = win_code;
      exl_d = 1'b1;
      // nested exception keeps the original return address
      if (!exl_q) epc_d = pc;
    end else begin
      if (eret_en) exl_d = 1'b0;
      if (mtc0_en && cp0_addr == CP0_STATUS) begin
        ie_d  = wdata[ST_IE];
        exl_d = wdata[ST_EXL];
        im_d  = wdata[ST_IM_HI:ST_IM_LO];
      end
      if (mtc0_en && cp0_addr == CP0_EPC) epc_d = wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ie_q  <= 1'b0;
      exl_q <= 1'b0;
      im_q  <= '0;
      exc_q <= '0;
      epc_q <= '0;
    end else begin
      ie_q  <= ie_d;
      exl_q <= exl_d;
      im_q  <= im_d;
      exc_q <= exc_d;
      epc_q <= epc_d;
    end
  end

  always_comb begin
    status_o = '0;
    status_o[ST_IE]  = ie_q;
    status_o[ST_EXL] = exl_q;
    status_o[ST_IM_HI:ST_IM_LO] = im_q;
    cause_o = '0;
    cause_o[CA_EXC_HI:CA_EXC_LO] = exc_q;
    cause_o[CA_IP_HI:CA_IP_LO]   = ip;
  end

  always_comb begin
    unique case (cp0_addr)
      CP0_COUNT:   rdata = count;
      CP0_COMPARE: rdata = compare;
      CP0_STATUS:  rdata = status_o;
      CP0_CAUSE:   rdata = cause_o;
      CP0_EPC:     rdata = epc_q;
      CP0_PRID:    rdata = PRID;
      default:     rdata = '0;
    endcase
  end

  assign cp0_target_addr = epc_q;

endmodule

// File: doc/cp0_unit.md
Name: cp0_unit

Overview:
Coprocessor-0 control block for the single-cycle MIPS core. It sits directly upstream of the program counter register. Each cycle it evaluates pending exceptions and interrupts against Status and drives hasExp and cp0_target_addr (EPC) into the PC. It also implements MTC0/MFC0 register access, ERET, and a Count/Compare timer that raises hardware interrupt IP7.

Parameters:
PRID, 32'h00018000, value returned for PRId (reg 15), read-only
TIMER_EN, 1, 1 = Count/Compare timer and IP7 implemented; 0 = Count frozen at 0, IP7 tied 0

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
pc  input  32  address of instruction currently executing
isCOP0  input  1  current instruction is a COP0-class op
isMtc0  input  1  MTC0 (qualified by isCOP0)
isMfc0  input  1  MFC0 (qualified by isCOP0)
isEret  input  1  ERET (qualified by isCOP0)
cp0_addr  input  5  CP0 register number (rd field)
wdata  input  32  GPR[rt] value for MTC0
ri_exc  input  1  reserved-instruction detected by decoder
sys_exc  input  1  SYSCALL decoded
ov_exc  input  1  arithmetic overflow from ALU
ext_int  input  5  level hardware interrupts, synchronous to clk, map to IP[6:2]
rdata  output  32  MFC0 read data, combinational
hasExp  output  1  exception taken this cycle; PC vectors and register file/memory writes of current instruction are suppressed
cp0_target_addr  output  32  current EPC value
status_o  output  32  Status register, debug/observe
cause_o  output  32  Cause register, debug/observe

Behaviour:
- Registers: Count(9), Compare(11), Status(12), Cause(13), EPC(14), PRId(15). All other addresses: reads return 0, writes are ignored.
- Status fields: IE=bit0, EXL=bit1, IM[7:2]=bits15:10. All other bits read 0 and are not writable.
- Cause fields: ExcCode=bits6:2, IP[7:2]=bits15:10. IP[6:2]=ext_int (live). IP7=timer_pending. Cause is not writable by MTC0.
- Reset values: Status=0, ExcCode=0, timer_pending=0, EPC=0, Count=0, Compare=32'hFFFFFFFF. hasExp=0 while rst is high.
- Interrupt request int_req = IE & ~EXL & |(IP[7:2] & IM[7:2]).
- Synchronous request sync_req = ri_exc | sys_exc | ov_exc. These are accepted regardless of IE or EXL.
- hasExp = int_req | sync_req. Combinational, same cycle, zero latency.
- Priority: interrupt (ExcCode 0) > RI (10) > Sys (8) > Ov (12).
- On the clock edge with hasExp=1:
  - ExcCode is written with the winning code.
  - EXL is set to 1.
  - If EXL was 0 before the edge, EPC is set to pc. If EXL was already 1, EPC is preserved.
- ERET (isCOP0 & isEret & ~hasExp): EXL is cleared at the edge. cp0_target_addr always shows EPC, so the PC returns to EPC.
- MTC0 (isCOP0 & isMtc0 & ~hasExp): writes the addressed register at the edge.
  - Writing Compare also clears timer_pending.
  - Writing Count loads wdata; no increment occurs that cycle.
- Any MTC0 or ERET in a cycle with hasExp=1 is suppressed; the exception wins.
- MFC0: rdata is the addressed register. It is driven for any cp0_addr regardless of isMfc0, and the writeback mux qualifies it.
- Timer (TIMER_EN=1):
  - Count increments by 1 every cycle and wraps at 2^32 silently.
  - At the edge where the pre-edge Count == Compare, timer_pending is set. It stays set until Compare is written.
  - A Compare write in the same cycle as a match leaves timer_pending cleared (the write wins).
- Reset asserted mid-operation returns every register to its reset value immediately.

Decomposition:
- Shared package cp0_pkg holds:
  - register numbers (CP0_COUNT=9, CP0_COMPARE=11, CP0_STATUS=12, CP0_CAUSE=13, CP0_EPC=14, CP0_PRID=15)
  - ExcCode constants (EXC_INT=0, EXC_SYS=8, EXC_RI=10, EXC_OV=12)
  - Status/Cause bit-position constants
- One natural sub-module: cp0_timer (Count, Compare, timer_pending, load/clear ports).

Test Plan:
- Reset, then MTC0 Status=32'h0000_8401, then program Count=0 and Compare=5 -> timer_pending sets at the edge after Count reaches 5. The next cycle asserts hasExp=1 with EPC=pc, ExcCode=0, and EXL=1.
- sys_exc=1 at pc=32'h0000_0040 -> hasExp=1 the same cycle. After the edge: EPC=32'h40, ExcCode=8, EXL=1. Then ERET -> EXL=0 and cp0_target_addr=32'h40.
- With EXL=1, assert ov_exc at pc=32'h0000_0100 -> hasExp=1 and ExcCode=12. EPC is unchanged (still 32'h40).
- MTC0 EPC=32'h1234 in the same cycle as ri_exc at pc=32'h0000_0200 -> the write is dropped. EPC=32'h200 and ExcCode=10.
- Hold ext_int=5'b00001 with IE=1 and IM2=0 -> hasExp=0. Set IM2 -> hasExp=1 the next cycle. MFC0 Cause reads bit10=1.
- MFC0 at addresses 15, 3, and 12 -> rdata = PRID, 0, and the current Status respectively. Assert rst mid-timer-count -> Count=0 and Compare=32'hFFFFFFFF.
